// File: rtl/ipg_slot_arbiter.sv
// Weighted two-way arbiter feeding a single-entry output register toward TX IPG insertion.
// Optional starvation guard for requester 1 is enabled by defining IPG_ARB_STARVE_GUARD_EN.
module ipg_slot_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int WEIGHT0      = 4,
    parameter int WEIGHT1      = 1,
    parameter int STARVE_LIMIT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  tx_pause,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  out_grant_id,
    output logic [15:0]           stat_grant0,
    output logic [15:0]           stat_grant1
);

    typedef enum logic {
        PTR0 = 1'b0,
        PTR1 = 1'b1
    } state_t;

    localparam logic [7:0] W0 = 8'(WEIGHT0);
    localparam logic [7:0] W1 = 8'(WEIGHT1);

    if (WEIGHT0 < 1 || WEIGHT0 > 255) begin : g_bad_weight0
        $error("WEIGHT0 out of range 1..255");
    end
    if (WEIGHT1 < 1 || WEIGHT1 > 255) begin : g_bad_weight1
        $error("WEIGHT1 out of range 1..255");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 1023) begin : g_bad_starve_limit
        $error("STARVE_LIMIT out of range 1..1023");
    end

    state_t     state;
    logic [7:0] cnt;

    logic       load_en;
    logic       grant_any;
    logic       sel;
    logic       favoured;
    logic       grant0;
    logic       grant1;
    logic [7:0] weight_cur;

`ifdef IPG_ARB_STARVE_GUARD_EN
    localparam logic [9:0] STARVE_THRESH = 10'(STARVE_LIMIT);
    logic [9:0] starve_cnt;
    logic       starve_hit;
    assign starve_hit = (starve_cnt >= STARVE_THRESH) && req1_valid;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        load_en    = !tx_pause && (!out_valid || out_ready);
        sel        = state;
        weight_cur = (state == PTR0) ? W0 : W1;

        // Work-conserving: fall back to the other requester when the favoured one is idle.
        if (state == PTR0) begin
            sel = req0_valid ? 1'b0 : 1'b1;
        end else begin
            sel = req1_valid ? 1'b1 : 1'b0;
        end
`ifdef IPG_ARB_STARVE_GUARD_EN
        if (starve_hit) begin
            sel = 1'b1;
        end
`endif
        favoured  = (sel == state);
        grant_any = !rst && load_en && (req0_valid || req1_valid);
        grant0    = grant_any && !sel;
        grant1    = grant_any && sel;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_grant_id <= 1'b0;
            state        <= PTR0;
            cnt          <= 8'd0;
            stat_grant0  <= 16'd0;
            stat_grant1  <= 16'd0;
`ifdef IPG_ARB_STARVE_GUARD_EN
            starve_cnt   <= 10'd0;
`endif
        end else begin
            if (grant_any) begin
                out_valid    <= 1'b1;
                out_data     <= sel ? req1_data : req0_data;
                out_grant_id <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (grant_any && favoured) begin
                if (cnt + 8'd1 == weight_cur) begin
                    state <= (state == PTR0) ? PTR1 : PTR0;
                    cnt   <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end

            if (grant0 && stat_grant0 != 16'hFFFF) begin
                stat_grant0 <= stat_grant0 + 16'd1;
            end
            if (grant1 && stat_grant1 != 16'hFFFF) begin
                stat_grant1 <= stat_grant1 + 16'd1;
            end

`ifdef IPG_ARB_STARVE_GUARD_EN
            if (grant1) begin
                starve_cnt <= 10'd0;
            end else if (req1_valid && starve_cnt != 10'h3FF) begin
                starve_cnt <= starve_cnt + 10'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ipg_slot_arbiter.sv
// Randomized bench: two arbiter instances (default and WEIGHT0=16/STARVE_LIMIT=8)
// compared every cycle against a credit-based reference model.
module tb_ipg_slot_arbiter;

    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          v0, v1, pause, ordy;
    logic [DW-1:0] d0, d1;

    logic          r0 [2];
    logic          r1 [2];
    logic          ov [2];
    logic          oid[2];
    logic [DW-1:0] od [2];
    logic [15:0]   s0 [2];
    logic [15:0]   s1 [2];

    ipg_slot_arbiter #(.DATA_WIDTH(DW)) u_dut_def (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0[0]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1[0]),
        .tx_pause(pause),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy), .out_grant_id(oid[0]),
        .stat_grant0(s0[0]), .stat_grant1(s1[0])
    );

    ipg_slot_arbiter #(.DATA_WIDTH(DW), .WEIGHT0(16), .WEIGHT1(1), .STARVE_LIMIT(8)) u_dut_w16 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0[1]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1[1]),
        .tx_pause(pause),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy), .out_grant_id(oid[1]),
        .stat_grant0(s0[1]), .stat_grant1(s1[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: favoured requester plus remaining credits in the current turn.
    int          w0  [2] = '{4, 16};
    int          w1  [2] = '{1, 1};
    int          lim [2] = '{32, 8};
    int          fav [2];
    int          credit[2];
    int          starve[2];
    logic        m_valid[2];
    logic        m_id   [2];
    logic [63:0] m_data [2];
    int          m_st0  [2];
    int          m_st1  [2];
    logic        last_g1[2];

    task automatic step(input logic rst_i, input logic v0_i, input logic v1_i,
                        input logic pause_i, input logic ordy_i);
        rst   = rst_i;
        v0    = v0_i;
        v1    = v1_i;
        pause = pause_i;
        ordy  = ordy_i;
        d0    = {$urandom, $urandom};
        d1    = {$urandom, $urandom};
        #4;
        for (int i = 0; i < 2; i++) begin
            int  pick;
            bit  force1;
            bit  load;
            pick   = -1;
            force1 = 1'b0;
            load   = !pause_i && (!m_valid[i] || ordy_i);
`ifdef IPG_ARB_STARVE_GUARD_EN
            force1 = (starve[i] >= lim[i]) && v1_i;
`endif
            if (!rst_i && load && (v0_i || v1_i)) begin
                if (force1) pick = 1;
                else if ((fav[i] == 0) ? v0_i : v1_i) pick = fav[i];
                else pick = 1 - fav[i];
            end
            check($sformatf("req0_ready[%0d]", i), 64'(r0[i]), 64'(pick == 0));
            check($sformatf("req1_ready[%0d]", i), 64'(r1[i]), 64'(pick == 1));
            last_g1[i] = r1[i];

            if (rst_i) begin
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
                m_id[i]    = 1'b0;
                fav[i]     = 0;
                credit[i]  = w0[i];
                starve[i]  = 0;
                m_st0[i]   = 0;
                m_st1[i]   = 0;
            end else begin
                if (pick >= 0) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = (pick == 1) ? d1 : d0;
                    m_id[i]    = (pick == 1);
                    if (pick == fav[i]) begin
                        credit[i]--;
                        if (credit[i] == 0) begin
                            fav[i]    = 1 - fav[i];
                            credit[i] = (fav[i] == 1) ? w1[i] : w0[i];
                        end
                    end
                    if (pick == 0 && m_st0[i] < 65535) m_st0[i]++;
                    if (pick == 1 && m_st1[i] < 65535) m_st1[i]++;
                end else if (ordy_i) begin
                    m_valid[i] = 1'b0;
                end
                if (pick == 1) starve[i] = 0;
                else if (v1_i && starve[i] < 1023) starve[i]++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(m_valid[i]));
            check($sformatf("out_data[%0d]", i), od[i], m_data[i]);
            check($sformatf("out_grant_id[%0d]", i), 64'(oid[i]), 64'(m_id[i]));
            check($sformatf("stat_grant0[%0d]", i), 64'(s0[i]), 64'(m_st0[i]));
            check($sformatf("stat_grant1[%0d]", i), 64'(s1[i]), 64'(m_st1[i]));
        end
    endtask

    task automatic first_grant1_run(input int exp0, input int exp1);
        int first[2];
        first = '{0, 0};
        step(1, 0, 0, 0, 1);
        for (int n = 1; n <= 40; n++) begin
            step(0, 1, 1, 0, 1);
            for (int i = 0; i < 2; i++)
                if (first[i] == 0 && last_g1[i]) first[i] = n;
        end
        check("first_grant1_def", 64'(first[0]), 64'(exp0));
        check("first_grant1_w16", 64'(first[1]), 64'(exp1));
    endtask

    initial begin
        int exp_w16;
        rst = 1'b1; v0 = 0; v1 = 0; pause = 0; ordy = 0; d0 = '0; d1 = '0;
        for (int i = 0; i < 2; i++) begin
            fav[i] = 0; credit[i] = w0[i]; starve[i] = 0;
            m_valid[i] = 0; m_data[i] = '0; m_id[i] = 0; m_st0[i] = 0; m_st1[i] = 0;
        end
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1);

`ifdef IPG_ARB_STARVE_GUARD_EN
        exp_w16 = 9;
`else
        exp_w16 = 17;
`endif
        // Default weights give 0,0,0,0,1; the heavy instance exposes the starvation bound.
        first_grant1_run(5, exp_w16);

        // Only requester 1 active, then both active with pause and stalled sink.
        step(1, 0, 0, 0, 1);
        repeat (10) step(0, 0, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        repeat (3) step(0, 1, 1, 1, 1);
        repeat (3) step(0, 1, 1, 0, 1);
        repeat (4) step(0, 1, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0, 1);

        // Reset while a chunk is held, then resume.
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (6) step(0, 1, 1, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipg_slot_arbiter.md
IPG_SLOT_ARBITER -- requirements
Module: ipg_slot_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of one IPG chunk.
REQ-002 Parameter WEIGHT0, default 4: consecutive favoured grants for requester 0 (reply queue), range 1..255.
REQ-003 Parameter WEIGHT1, default 1: consecutive favoured grants for requester 1 (memory/bulk queue), range 1..255.
REQ-004 Parameter STARVE_LIMIT, default 32: starvation threshold in cycles, range 1..1023; used only under REQ-030.
REQ-005 Port clk, input, 1: the single clock; all logic is rising-edge synchronous.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Ports req0_valid input 1, req0_data input DATA_WIDTH, req0_ready output 1: requester 0 valid/ready channel.
REQ-008 Ports req1_valid input 1, req1_data input DATA_WIDTH, req1_ready output 1: requester 1 valid/ready channel.
REQ-009 Port tx_pause, input, 1: TX-side backpressure; high blocks new grants.
REQ-010 Ports out_valid output 1, out_data output DATA_WIDTH, out_ready input 1: chunk toward TX IPG insertion.
REQ-011 Port out_grant_id, output, 1: requester index of the chunk currently in out_data.
REQ-012 Ports stat_grant0 and stat_grant1, output, 16 each: saturating grant counters.

Function
REQ-013 Output register (out_valid/out_data/out_grant_id) SHALL be a single entry; transfer occurs on out_valid && out_ready.
REQ-014 load_en = !tx_pause && (!out_valid || out_ready); a grant SHALL occur only when load_en && (req0_valid || req1_valid).
REQ-015 reqN_ready SHALL be combinational, high only in the cycle requester N is granted; at most one ready high per cycle.
REQ-016 Granted chunk SHALL appear on out_data with out_valid high the cycle after the grant (latency 1); consume and load in the same cycle SHALL sustain one chunk per cycle.
REQ-017 With out_valid high and out_ready low, out_data and out_grant_id SHALL remain stable.
REQ-018 If out_valid && out_ready and no grant, out_valid SHALL fall next cycle.
REQ-019 FSM states PTR0, PTR1 (favoured requester) plus credit counter cnt (8 bits).
REQ-020 In PTRn, grant favoured n if reqn_valid, else the other requester (work-conserving).
REQ-021 Favoured grant: cnt increments; when cnt+1 equals WEIGHTn, state toggles and cnt clears.
REQ-022 Non-favoured grant SHALL leave state and cnt unchanged.
REQ-023 No grant (idle or paused) SHALL leave state and cnt unchanged.
REQ-024 tx_pause SHALL not clear out_valid; a held chunk may still drain while paused.
REQ-025 stat_grantN SHALL increment on each grant to N, saturating at 16'hFFFF.

Reset
REQ-026 On rst: out_valid 0, out_data 0, out_grant_id 0, state PTR0, cnt 0, starve counter 0, stat_grant0/1 0.
REQ-027 reqN_ready SHALL be 0 while rst is high.
REQ-028 Reset mid-operation SHALL discard a held chunk; no transfer occurs in the reset cycle.
REQ-029 First grant after reset SHALL follow PTR0 rules.

Configuration
REQ-030 Macro IPG_ARB_STARVE_GUARD_EN defined: 10-bit counter increments each cycle req1_valid is high and requester 1 not granted, clears on grant 1; upon reaching STARVE_LIMIT, next grant SHALL go to requester 1 regardless of state, counting as non-favoured unless in PTR1.
REQ-031 Macro undefined: no starve counter exists; arbitration is purely REQ-020..REQ-023.

Verification
REQ-032 Both valid continuously, out_ready=1, defaults -> grant ids 0,0,0,0,1 repeating, one per cycle, each chunk on out_data one cycle after its ready.
REQ-033 Only req1_valid, 10 cycles -> 10 consecutive grants to 1, state remains PTR0, cnt 0.
REQ-034 Both valid, tx_pause high 3 cycles after the second grant -> both ready low 3 cycles, out chunk held and drained; resumes with 0,0,1.
REQ-035 out_ready low 4 cycles with out_valid high -> out_data stable, no ready; out_ready high -> consume and new load same cycle.
REQ-036 WEIGHT0=16, STARVE_LIMIT=8, both valid -> with macro first grant 1 after 8 waiting cycles (9th grant); without, 17th grant.
REQ-037 rst asserted while out_valid high -> next cycle out_valid 0, stats 0, state PTR0; first post-reset grant to 0.
